// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO feeding a CORDIC rotator: folds the phase into [-pi/2, pi/2)
// and delays the matching negate flag by the rotator latency.
module nco_phase_gen #(
  parameter int PHASE_WIDTH = 32,
  parameter int ANGLE_WIDTH = 32,
  parameter int PIPE_DELAY  = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PHASE_WIDTH-1:0] fcw_in,
  input  logic                   fcw_valid,
  output logic                   fcw_ready,
  input  logic                   phase_clr,
  input  logic [PHASE_WIDTH-1:0] phase_offset_in,
  output logic [ANGLE_WIDTH-1:0] angle_out,
  output logic                   angle_valid,
  output logic                   flip_out,
  output logic                   flip_valid
);

  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] fcw_act;
  logic [PHASE_WIDTH-1:0] fcw_pend;
  logic                   pend_v;
  logic                   flip_r;

  logic [PHASE_WIDTH-1:0] fold_phase;
  logic                   fold_flip;

  logic dly_flip [PIPE_DELAY];
  logic dly_vld  [PIPE_DELAY];

  assign fcw_ready = !pend_v;

  // Quadrants II/III are moved by +/-pi (toggle the MSB); the rotator output is negated later.
  always_comb begin
    fold_phase = acc;
    fold_flip  = 1'b0;
    if (acc[PHASE_WIDTH-1] != acc[PHASE_WIDTH-2]) begin
      fold_phase = {~acc[PHASE_WIDTH-1], acc[PHASE_WIDTH-2:0]};
      fold_flip  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcw_pend <= '0;
      pend_v   <= 1'b0;
      fcw_act  <= '0;
    end else if (fcw_valid && !pend_v) begin
      fcw_pend <= fcw_in;
      pend_v   <= 1'b1;
    end else if (en && pend_v) begin
      fcw_act <= fcw_pend;
      pend_v  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (phase_clr) begin
      acc <= phase_offset_in;
    end else if (en) begin
      acc <= acc + fcw_act;
    end
  end

  // Samples the pre-update phase, so a phase_clr cycle still emits the old phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_out   <= '0;
      angle_valid <= 1'b0;
      flip_r      <= 1'b0;
    end else if (en) begin
      angle_out   <= fold_phase[PHASE_WIDTH-1 -: ANGLE_WIDTH];
      angle_valid <= 1'b1;
      flip_r      <= fold_flip;
    end else begin
      angle_valid <= 1'b0;
    end
  end

  // Free-running, like the rotator pipeline it tracks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        dly_flip[i] <= 1'b0;
        dly_vld[i]  <= 1'b0;
      end
    end else begin
      dly_flip[0] <= flip_r & angle_valid;
      dly_vld[0]  <= angle_valid;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        dly_flip[i] <= dly_flip[i-1];
        dly_vld[i]  <= dly_vld[i-1];
      end
    end
  end

  assign flip_out   = dly_flip[PIPE_DELAY-1];
  assign flip_valid = dly_vld[PIPE_DELAY-1];

endmodule

// File: tb/tb_nco_phase_gen.sv
// Scoreboard bench for nco_phase_gen: a behavioural phase model queues expected
// angle/flip samples, compared as angle_valid and flip_valid arrive.
module tb_nco_phase_gen;
  localparam int PW = 32;
  localparam int AW = 32;
  localparam int PD = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [PW-1:0] fcw_in = '0;
  logic          fcw_valid = 1'b0;
  logic          fcw_ready;
  logic          phase_clr = 1'b0;
  logic [PW-1:0] phase_offset_in = '0;
  logic [AW-1:0] angle_out;
  logic          angle_valid;
  logic          flip_out;
  logic          flip_valid;

  nco_phase_gen #(.PHASE_WIDTH(PW), .ANGLE_WIDTH(AW), .PIPE_DELAY(PD)) dut (
    .clk(clk), .rst(rst), .en(en), .fcw_in(fcw_in), .fcw_valid(fcw_valid),
    .fcw_ready(fcw_ready), .phase_clr(phase_clr), .phase_offset_in(phase_offset_in),
    .angle_out(angle_out), .angle_valid(angle_valid), .flip_out(flip_out),
    .flip_valid(flip_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;

  logic [PW-1:0] m_acc, m_act, m_pend;
  logic          m_pv;
  logic [32:0]   angle_q [$];
  int            flip_due_q [$];
  logic          flip_exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Angle in [pi/2, 3pi/2) is shifted by pi and flagged for negation.
  function automatic logic [32:0] ref_fold(input logic [31:0] a);
    if (a >= 32'h4000_0000 && a < 32'hC000_0000) return {1'b1, a - 32'h8000_0000};
    return {1'b0, a};
  endfunction

  task automatic model_clear();
    m_acc = '0; m_act = '0; m_pend = '0; m_pv = 1'b0;
    angle_q.delete(); flip_due_q.delete(); flip_exp_q.delete();
  endtask

  task automatic cyc(input logic e, input logic clr, input logic [31:0] off,
                     input logic fv, input logic [31:0] fw);
    logic [31:0] nxt;
    logic [32:0] s;
    en = e; phase_clr = clr; phase_offset_in = off; fcw_valid = fv; fcw_in = fw;
    if (e) angle_q.push_back(ref_fold(m_acc));
    nxt = clr ? off : (e ? m_acc + m_act : m_acc);
    if (fv && !m_pv) begin
      m_pend = fw; m_pv = 1'b1;
    end else if (e && m_pv) begin
      m_act = m_pend; m_pv = 1'b0;
    end
    m_acc = nxt;
    @(posedge clk); #1;
    cycle++;
    chk("angle_valid", {63'd0, angle_valid}, {63'd0, e});
    if (angle_valid) begin
      if (angle_q.size() == 0) begin
        chk("angle_unexpected", 64'd1, 64'd0);
      end else begin
        s = angle_q.pop_front();
        chk("angle", {32'd0, angle_out}, {32'd0, s[31:0]});
        flip_exp_q.push_back(s[32]);
        flip_due_q.push_back(cycle + PD);
      end
    end
    if (flip_due_q.size() > 0 && flip_due_q[0] == cycle) begin
      chk("flip_valid", {63'd0, flip_valid}, 64'd1);
      chk("flip", {63'd0, flip_out}, {63'd0, flip_exp_q[0]});
      void'(flip_due_q.pop_front());
      void'(flip_exp_q.pop_front());
    end else if (flip_valid) begin
      chk("flip_valid_spurious", 64'd1, 64'd0);
    end
    chk("fcw_ready", {63'd0, fcw_ready}, {63'd0, !m_pv});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_angle"}, {32'd0, angle_out}, 64'd0);
    chk({tag, "_avalid"}, {63'd0, angle_valid}, 64'd0);
    chk({tag, "_flip"}, {63'd0, flip_out}, 64'd0);
    chk({tag, "_fvalid"}, {63'd0, flip_valid}, 64'd0);
    chk({tag, "_ready"}, {63'd0, fcw_ready}, 64'd1);
  endtask

  initial begin
    model_clear();
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // idle: no valid for 20 cycles
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0);

    // basic sweep
    cyc(1'b0, 1'b0, '0, 1'b1, 32'h1000_0000);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("sweep_1", {32'd0, angle_out}, 64'h1000_0000);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("sweep_3", {32'd0, angle_out}, 64'h3000_0000);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("sweep_4", {32'd0, angle_out}, 64'hC000_0000);
    for (int i = 0; i < PD + 2; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0);

    // quadrant folds at -pi and just below -pi/2
    cyc(1'b1, 1'b1, 32'h8000_0000, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("fold_mpi", {32'd0, angle_out}, 64'h0);
    cyc(1'b0, 1'b1, 32'hBFFF_FFFF, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("fold_bfff", {32'd0, angle_out}, 64'h3FFF_FFFF);

    // handshake: second word refused while pending, no apply with en low
    cyc(1'b0, 1'b0, '0, 1'b1, 32'h2000_0000);
    chk("hs_ready_low", {63'd0, fcw_ready}, 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1, 32'h7777_7777);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0);
    chk("hs_still_pending", {63'd0, fcw_ready}, 64'd0);

    // phase_clr + en + apply together, then wrap past 2^32
    cyc(1'b1, 1'b1, 32'hF000_0000, 1'b0, '0);
    chk("clr_ready_back", {63'd0, fcw_ready}, 64'd1);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("wrap_0", {32'd0, angle_out}, 64'hF000_0000);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("wrap_1", {32'd0, angle_out}, 64'h1000_0000);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("wrap_2", {32'd0, angle_out}, 64'h3000_0000);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0, 1'b0, '0);

    // async reset mid-stream with a word pending
    cyc(1'b1, 1'b0, '0, 1'b1, 32'h0100_0000);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    en = 1'b0; fcw_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    chk("post_rst_acc", {32'd0, angle_out}, 64'h0);

    for (int i = 0; i < PD + 3; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0);
    chk("drain_flip_q", flip_due_q.size(), 64'd0);
    chk("drain_angle_q", angle_q.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/nco_phase_gen.md
# nco_phase_gen

Phase-accumulator NCO that sits directly upstream of the CORDIC sine/cosine rotator. Each enabled cycle it advances a PHASE_WIDTH-bit phase by a frequency control word (FCW). It folds the phase into the rotator's convergence range [-π/2, π/2) and presents it as the rotator's angle input. It also delays a per-sample "negate" flag by the rotator's pipeline latency, so the downstream mixer can restore the full-circle sign.

## Interface
- PHASE_WIDTH, 32: accumulator width; the full circle is 2^PHASE_WIDTH.
- ANGLE_WIDTH, 32: output angle width, ≤ PHASE_WIDTH; the top ANGLE_WIDTH bits of the folded phase.
- PIPE_DELAY, 14: rotator latency in cycles from angle input to registered x/y output; ≥ 1.

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  advance the phase this cycle
- fcw_in  in  PHASE_WIDTH  new frequency word, unsigned
- fcw_valid  in  1  fcw_in offered
- fcw_ready  out  1  pending slot free
- phase_clr  in  1  synchronous phase reload
- phase_offset_in  in  PHASE_WIDTH  value loaded on phase_clr
- angle_out  out  ANGLE_WIDTH  folded angle, signed; ±2^(ANGLE_WIDTH-1) = ±π
- angle_valid  out  1  angle_out carries a new sample
- flip_out  out  1  negate the rotator x/y for the sample now leaving the rotator
- flip_valid  out  1  flip_out qualifier, aligned with the rotator output

## Operation
- Registers:
  - acc: phase, PHASE_WIDTH bits
  - fcw_act: active FCW
  - fcw_pend, pend_v: pending FCW and its valid bit
  - output register: angle, valid, flip
  - flip delay line: PIPE_DELAY stages of {flip, valid}
- Async reset clears every register to 0, so acc=0, fcw_act=0 and pend_v=0. Every output reads 0 at reset except fcw_ready, which reads 1.
- fcw_ready = !pend_v. A transfer occurs when fcw_valid && fcw_ready: fcw_pend <= fcw_in and pend_v <= 1.
- Apply rule: on a cycle with en=1 and pend_v=1, fcw_act <= fcw_pend and pend_v <= 0. The add on that same cycle still uses the old fcw_act; the new word first takes effect on the next enabled cycle.
- A transfer and an apply in the same cycle are impossible, because ready is low while pend_v=1. At most one word can be pending.
- Accumulator update:
  - phase_clr=1: acc <= phase_offset_in. No add that cycle, even with en=1.
  - else en=1: acc <= acc + fcw_act, wrapping mod 2^PHASE_WIDTH with no saturation.
  - else: acc holds.
- Fold, combinational on the current acc. Let m1 = acc[MSB] and m2 = acc[MSB-1].
  - m1 == m2 (quadrants I/IV): f = acc, flip = 0.
  - m1 != m2: f = {~m1, acc[MSB-1:0]}, i.e. acc ± π, and flip = 1.
  - Result: f lies in [-2^(PHASE_WIDTH-2), 2^(PHASE_WIDTH-2)).
  - The angle is f[PHASE_WIDTH-1 -: ANGLE_WIDTH], truncated without rounding.
- Output register: when en=1 (including cycles where phase_clr=1), angle_out <= fold(acc) using the pre-update acc, angle_valid <= 1, and the flip stage-0 <= flip. When en=0, angle_valid <= 0 and angle_out holds.
- The delay line shifts every cycle regardless of en, matching the free-running rotator pipeline. flip_out/flip_valid are the last stage.

## Timing
- angle latency: 1 cycle from the en cycle to angle_valid. The sample carries the phase accumulated before that cycle's add.
- flip latency: flip_valid rises exactly PIPE_DELAY cycles after the corresponding angle_valid.
- phase_clr at cycle t makes acc = offset at t+1. The first angle_out equal to the folded offset appears after the first en cycle at or after t+1.
- FCW handshake: a word accepted at t with en held high updates fcw_act at the t+1 edge. The increment changes from t+2 onward, and fcw_ready returns high at t+2.
- Reset mid-stream: all outputs drop immediately and asynchronously. A pending word is discarded, and the flip line contents are lost.

## Test plan
- Reset and idle: assert rst with en=0 → all outputs 0, fcw_ready=1, and angle_valid stays 0 across 20 cycles.
- Basic sweep (PHASE_WIDTH=ANGLE_WIDTH=32): FCW=0x1000_0000, en held high → angle_out sequence 0x0, 0x1000_0000, 0x2000_0000, 0x3000_0000.
  - The next sample is acc=0x4000_0000 → angle 0xC000_0000 with flip=1, and flip_valid rises PIPE_DELAY cycles later.
- Wrap-around: phase_clr with offset 0xF000_0000, FCW=0x2000_0000 → samples 0xF000_0000 (flip 0), then 0x1000_0000 (flip 0) after the 2^32 wrap.
- Quadrant fold at acc=0x8000_0000 (-π) → angle 0x0 with flip=1; acc=0xBFFF_FFFF → angle 0x3FFF_FFFF with flip=1.
- FCW handshake: offer a word while pend_v=1 → fcw_ready=0 and the word is not taken. With en=0 the pending word is not applied; raising en applies it with the 1-cycle rule.
- Simultaneous events: phase_clr=1 with en=1 and pending apply → acc = offset with no add, fcw_act updated, and angle_valid=1 carrying the old phase. Async rst pulse mid-stream → outputs 0 immediately.
